// File: rtl/lenet_pkg.sv
// Shared LeNet constants: data widths, per-layer pooled-map geometry and the
// pool/cut-out FSM encoding.
package lenet_pkg;
   localparam int DATA_SIZE      = 8;
   localparam int HALFWORD_WIDTH = 16;
   localparam int KENNEL_SIZE    = 5;

   localparam int L1_OUT_DIM = 12;
   localparam int L1_SHIFT   = 4;
   localparam int L2_OUT_DIM = 4;
   localparam int L2_SHIFT   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pool_state_t;
endpackage

// File: rtl/conv_pool_cutout_if.sv
// Bus between the convolutor front end and the pooling/cut-out stage.
interface conv_pool_cutout_if #(
   parameter int DATA_SIZE      = 8,
   parameter int HALFWORD_WIDTH = 16,
   parameter int ADDR_W         = 8
);
   logic                      start;
   logic                      covResVld;
   logic [HALFWORD_WIDTH-1:0] num1;
   logic [HALFWORD_WIDTH-1:0] num2;
   logic [HALFWORD_WIDTH-1:0] num3;
   logic [HALFWORD_WIDTH-1:0] num4;
   logic                      poolVld;
   logic [DATA_SIZE-1:0]      poolPix;
   logic [ADDR_W-1:0]         poolAddr;
   logic                      mapDone;
   logic                      busy;
   logic                      err;

   modport slave (
      input  start, covResVld, num1, num2, num3, num4,
      output poolVld, poolPix, poolAddr, mapDone, busy, err
   );

   modport master (
      output start, covResVld, num1, num2, num3, num4,
      input  poolVld, poolPix, poolAddr, mapDone, busy, err
   );
endinterface

// File: rtl/conv_pool_cutout_relu_cut_sat.sv
// Combinational ReLU, fixed-point rescale and saturation to a positive
// signed OUT_W-bit value; shared with the fully-connected stages.
module relu_cut_sat #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int SHIFT = 4
) (
   input  logic [IN_W-1:0]  i_val,
   output logic [OUT_W-1:0] o_pix
);
   localparam logic [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);

   logic [IN_W-1:0] w_relu;
   logic [IN_W-1:0] w_cut;

   // Clamp negatives, shift down, then clip to the largest positive code.
   always_comb begin
      w_relu = i_val;
      if (i_val[IN_W-1]) begin
         w_relu = '0;
      end else begin
         w_relu = i_val;
      end
      w_cut = $unsigned($signed(w_relu) >>> SHIFT);
      if (w_cut > SAT_MAX) begin
         o_pix = SAT_MAX[OUT_W-1:0];
      end else begin
         o_pix = w_cut[OUT_W-1:0];
      end
   end
endmodule

// File: rtl/conv_pool_cutout.sv
// 2x2 max-pool + ReLU/cut-out/saturate over groups of four conv sums, with
// raster addressing of the pooled map and a done pulse on its last pixel.
module conv_pool_cutout #(
   parameter int DATA_SIZE      = lenet_pkg::DATA_SIZE,
   parameter int HALFWORD_WIDTH = lenet_pkg::HALFWORD_WIDTH,
   parameter int OUT_DIM        = lenet_pkg::L1_OUT_DIM,
   parameter int SHIFT          = lenet_pkg::L1_SHIFT,
   parameter int ADDR_W         = 8
) (
   input logic               clk,
   input logic               rst,
   conv_pool_cutout_if.slave bus
);
   import lenet_pkg::*;

   localparam int MAP_PIX = OUT_DIM * OUT_DIM;
   localparam int CNT_W   = ADDR_W + 1;

   pool_state_t               r_state;
   pool_state_t               w_next_state;
   logic [CNT_W-1:0]          r_acc_cnt;
   logic                      w_accept;
   logic                      w_drop;
   logic [HALFWORD_WIDTH-1:0] w_max12;
   logic [HALFWORD_WIDTH-1:0] w_max34;
   logic [HALFWORD_WIDTH-1:0] w_max;
   logic [DATA_SIZE-1:0]      w_pix;

   logic                      r_s1_vld;
   logic [HALFWORD_WIDTH-1:0] r_s1_a;
   logic [HALFWORD_WIDTH-1:0] r_s1_b;
   logic [ADDR_W-1:0]         r_s1_addr;
   logic                      r_s1_last;

   logic                      r_pool_vld;
   logic [DATA_SIZE-1:0]      r_pool_pix;
   logic [ADDR_W-1:0]         r_pool_addr;
   logic                      r_map_done;
   logic                      r_busy;
   logic                      r_err;

   // Next-state: leave RUN in the cycle the done pulse is on the outputs.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next_state = ST_RUN;
            else           w_next_state = ST_IDLE;
         end
         ST_RUN: begin
            if (r_map_done) w_next_state = ST_IDLE;
            else            w_next_state = ST_RUN;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_accept = bus.covResVld && (r_state == ST_RUN) && (r_acc_cnt < CNT_W'(MAP_PIX));
   assign w_drop   = bus.covResVld && !w_accept;
   assign w_max12  = ($signed(bus.num1) > $signed(bus.num2)) ? bus.num1 : bus.num2;
   assign w_max34  = ($signed(bus.num3) > $signed(bus.num4)) ? bus.num3 : bus.num4;
   assign w_max    = ($signed(r_s1_a) > $signed(r_s1_b)) ? r_s1_a : r_s1_b;

   relu_cut_sat #(
      .IN_W  (HALFWORD_WIDTH),
      .OUT_W (DATA_SIZE),
      .SHIFT (SHIFT)
   ) u_relu_cut_sat (
      .i_val (w_max),
      .o_pix (w_pix)
   );

   // FSM, accept counter, busy and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_acc_cnt <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == ST_RUN);
         r_err   <= r_err | w_drop;
         if ((r_state == ST_IDLE) && bus.start) begin
            r_acc_cnt <= '0;
         end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
         end else begin
            r_acc_cnt <= r_acc_cnt;
         end
      end
   end

   // Stage 1: pairwise row maxima, address and last flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_a    <= '0;
         r_s1_b    <= '0;
         r_s1_addr <= '0;
         r_s1_last <= 1'b0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_a    <= w_max12;
            r_s1_b    <= w_max34;
            r_s1_addr <= r_acc_cnt[ADDR_W-1:0];
            r_s1_last <= (r_acc_cnt == CNT_W'(MAP_PIX - 1));
         end else begin
            r_s1_a    <= r_s1_a;
            r_s1_b    <= r_s1_b;
            r_s1_addr <= r_s1_addr;
            r_s1_last <= r_s1_last;
         end
      end
   end

   // Stage 2: final max and cut-out; pixel/address hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pool_vld  <= 1'b0;
         r_pool_pix  <= '0;
         r_pool_addr <= '0;
         r_map_done  <= 1'b0;
      end else begin
         r_pool_vld <= r_s1_vld;
         r_map_done <= r_s1_vld & r_s1_last;
         if (r_s1_vld) begin
            r_pool_pix  <= w_pix;
            r_pool_addr <= r_s1_addr;
         end else begin
            r_pool_pix  <= r_pool_pix;
            r_pool_addr <= r_pool_addr;
         end
      end
   end

   assign bus.poolVld  = r_pool_vld;
   assign bus.poolPix  = r_pool_pix;
   assign bus.poolAddr = r_pool_addr;
   assign bus.mapDone  = r_map_done;
   assign bus.busy     = r_busy;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_conv_pool_cutout.sv
// Directed bench for conv_pool_cutout with a cycle-indexed behavioural model.
module tb_conv_pool_cutout;
   localparam int OUT_DIM = 12;
   localparam int MAP_PIX = OUT_DIM * OUT_DIM;
   localparam int SHIFT   = 4;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;

   conv_pool_cutout_if #(.DATA_SIZE(8), .HALFWORD_WIDTH(16), .ADDR_W(8)) bus ();

   conv_pool_cutout #(
      .DATA_SIZE(8), .HALFWORD_WIDTH(16), .OUT_DIM(OUT_DIM), .SHIFT(SHIFT), .ADDR_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: expected outputs keyed by the cycle they must appear in.
   int  exp_pix[int];
   int  exp_addr[int];
   bit  exp_last[int];
   bit  m_run, m_err, m_done_known;
   int  m_cnt, m_done_cyc, m_rst_cyc;
   bit  exp_busy, exp_err, chk_on;
   int  last_pix, last_addr, n_vld, n_done;

   function automatic int model_pix(input logic [15:0] a, b, c, d);
      int v[4];
      int m;
      v[0] = $signed(a); v[1] = $signed(b); v[2] = $signed(c); v[3] = $signed(d);
      m = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
      if (m < 0) m = 0;
      m = m / (1 << SHIFT);
      return (m > 127) ? 127 : m;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
      end
   endtask

   // One clock of stimulus; the model decides acceptance from its own state.
   task automatic drive(input bit r, input bit s, input bit v,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
      bit running;
      int stale[$];
      running  = m_run && !(m_done_known && cyc >= m_done_cyc + 1);
      m_run    = running;
      exp_busy = running;
      exp_err  = m_err;
      if (r) begin
         m_run = 0; m_err = 0; m_cnt = 0; m_done_known = 0;
         m_rst_cyc = cyc + 1;
         foreach (exp_pix[k]) if (k >= cyc + 1) stale.push_back(k);
         foreach (stale[i]) begin
            exp_pix.delete(stale[i]); exp_addr.delete(stale[i]); exp_last.delete(stale[i]);
         end
      end else begin
         if (v) begin
            if (running && m_cnt < MAP_PIX) begin
               exp_pix[cyc + 2]  = model_pix(a, b, c, d);
               exp_addr[cyc + 2] = m_cnt;
               exp_last[cyc + 2] = (m_cnt == MAP_PIX - 1);
               if (m_cnt == MAP_PIX - 1) begin
                  m_done_known = 1;
                  m_done_cyc   = cyc + 2;
               end
               m_cnt++;
            end else begin
               m_err = 1;
            end
         end
         if (s && !running) begin
            m_run = 1; m_cnt = 0; m_done_known = 0;
         end
      end
      rst = r; bus.start = s; bus.covResVld = v;
      bus.num1 = a; bus.num2 = b; bus.num3 = c; bus.num4 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic grp(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
      drive(1'b0, 1'b0, 1'b1, a, b, c, d);
   endtask

   // Compare every output against the model on every cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         int  ep, ea;
         bit  ev, el;
         if (cyc == m_rst_cyc) begin
            last_pix = 0; last_addr = 0;
         end
         if (exp_pix.exists(cyc)) begin
            ev = 1; ep = exp_pix[cyc]; ea = exp_addr[cyc]; el = exp_last[cyc];
            exp_pix.delete(cyc); exp_addr.delete(cyc); exp_last.delete(cyc);
            last_pix = ep; last_addr = ea;
         end else begin
            ev = 0; el = 0; ep = last_pix; ea = last_addr;
         end
         chk("poolVld",  int'(bus.poolVld),  int'(ev));
         chk("mapDone",  int'(bus.mapDone),  int'(el));
         chk("poolPix",  int'(bus.poolPix),  ep);
         chk("poolAddr", int'(bus.poolAddr), ea);
         chk("busy",     int'(bus.busy),     int'(exp_busy));
         chk("err",      int'(bus.err),      int'(exp_err));
         if (bus.poolVld === 1'b1) n_vld++;
         if (bus.mapDone === 1'b1) n_done++;
      end
   end

   initial begin
      int v0, d0;
      checks = 0; failures = 0; chk_on = 0;
      m_run = 0; m_err = 0; m_cnt = 0; m_done_known = 0; m_done_cyc = 0; m_rst_cyc = -1;
      last_pix = 0; last_addr = 0; n_vld = 0; n_done = 0;
      rst = 1'b1; bus.start = 1'b0; bus.covResVld = 1'b0;
      bus.num1 = '0; bus.num2 = '0; bus.num3 = '0; bus.num4 = '0;
      @(posedge clk);
      #1;
      chk_on = 1;

      // Literal anchors for the pixel model.
      chk("model_basic", model_pix(16'h0100, 16'h0050, 16'hFF00, 16'h0020), 16);
      chk("model_sat",   model_pix(16'h7FFF, 16'h0000, 16'h0000, 16'h0000), 127);
      chk("model_neg",   model_pix(16'h8000, 16'hFFF0, 16'hC000, 16'hFFFF), 0);
      chk("model_trunc", model_pix(16'h000F, 16'h0000, 16'h0000, 16'h0000), 0);

      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      idle(2);

      // Group before start: dropped, err set.
      grp(16'h0100, 16'h0, 16'h0, 16'h0);
      idle(3);
      chk("err_before_start", int'(bus.err), 1);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

      // Basic, saturation, negative and truncation groups.
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      grp(16'h0100, 16'h0050, 16'hFF00, 16'h0020);
      idle(1);
      chk("basic_pix", int'(bus.poolPix), 16);
      chk("basic_addr", int'(bus.poolAddr), 0);
      grp(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
      grp(16'h8000, 16'hFFF0, 16'hC000, 16'hFFFF);
      grp(16'h000F, 16'h0000, 16'h0000, 16'h0000);
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

      // Full map back-to-back, then a 145th group that must be dropped.
      v0 = n_vld; d0 = n_done;
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < MAP_PIX; i++) grp(16'(i << 4), 16'h0, 16'h0, 16'h0);
      grp(16'h0100, 16'h0, 16'h0, 16'h0);
      idle(5);
      chk("full_vld_count", n_vld - v0, MAP_PIX);
      chk("full_done_count", n_done - d0, 1);
      chk("full_err", int'(bus.err), 1);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

      // start during RUN is ignored; addresses continue.
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 10; i++) grp(16'(i * 40), 16'h0, 16'h0, 16'h0);
      drive(1'b0, 1'b1, 1'b1, 16'h0500, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 5; i++) grp(16'h0, 16'(i * 100), 16'h0, 16'h0);
      idle(2);
      chk("restart_ignored_addr", int'(bus.poolAddr), 15);

      // Reset mid-map with groups in flight, then a fresh map starts at 0.
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 50; i++) grp(16'h0, 16'h0, 16'(i * 16), 16'h0);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      v0 = n_vld;
      idle(4);
      chk("no_vld_after_rst", n_vld - v0, 0);
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      grp(16'h0, 16'h0, 16'h0, 16'h0333);
      idle(1);
      chk("rst_restart_addr", int'(bus.poolAddr), 0);
      chk("rst_restart_pix", int'(bus.poolPix), 51);
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

      // Gapped random stream over a full map.
      v0 = n_vld; d0 = n_done;
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      while (m_cnt < MAP_PIX) begin
         drive(1'b0, 1'b0, 1'($urandom_range(0, 1)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      end
      while (cyc < m_done_cyc) idle(1);
      // start in the mapDone cycle is ignored, one cycle later it is taken.
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      grp(16'h0200, 16'h0, 16'h0, 16'h0);
      idle(4);
      chk("gap_vld_count", n_vld - v0, MAP_PIX + 1);
      chk("gap_done_count", n_done - d0, 1);
      chk("gap_next_map_addr", int'(bus.poolAddr), 0);
      chk("gap_err_clear", int'(bus.err), 0);

      chk_on = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_pool_cutout.md
# conv_pool_cutout

Downstream stage of the four-way 5×5 convolutor. Consumes each group of four 16-bit convolution sums (one 2×2 output neighbourhood) and applies 2×2 max-pooling, ReLU, fixed-point cut-out and saturation to 8 bits. Emits one pooled pixel per group with its raster address into the pooled feature map. Tracks map position and pulses done when a full pooled map has been written.

## Interface

Parameters:
- DATA_SIZE, 8, output pixel width
- HALFWORD_WIDTH, 16, input sum width (signed two's complement)
- OUT_DIM, 12, pooled map side; the map holds OUT_DIM*OUT_DIM pixels
- SHIFT, 4, arithmetic right shift applied after ReLU (fixed-point rescale)
- ADDR_W, 8, address width; must satisfy 2^ADDR_W ≥ OUT_DIM*OUT_DIM

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms the block for a new map
- covResVld  in  1  num1..num4 valid this cycle
- num1, num2, num3, num4  in  16 each  signed conv sums (top-left, top-right, bottom-left, bottom-right)
- poolVld  out  1  poolPix/poolAddr valid
- poolPix  out  8  pooled, ReLU'd, saturated pixel (signed, range 0..127)
- poolAddr  out  ADDR_W  raster index row*OUT_DIM+col
- mapDone  out  1  one-cycle pulse with the last pixel of a map
- busy  out  1  high from accepted start until mapDone cycle inclusive
- err  out  1  sticky; covResVld arrived while not accepting

## Operation

- FSM states: IDLE, RUN.
  - IDLE → RUN on start; clears the accept counter.
  - RUN → IDLE in the cycle mapDone is asserted.
  - start during RUN is ignored (no restart, no err).
- Accept rule: a group is accepted when covResVld=1, state=RUN and acceptCnt < OUT_DIM². Accepted groups take address acceptCnt, and acceptCnt increments.
- err is set and the group dropped on any of these; only rst clears err:
  - covResVld while IDLE.
  - covResVld in RUN after OUT_DIM² groups have been accepted but before mapDone.
- Stage 1 registers max(num1,num2) and max(num3,num4) as signed compares, with the address and a last flag.
- Stage 2 computes, then registers:
  - m = signed max of the stage-1 pair.
  - r = (m<0) ? 0 : m.
  - c = r >>> SHIFT, truncating.
  - poolPix = (c>127) ? 127 : c[7:0].
- last flag = (address == OUT_DIM²−1). mapDone = poolVld & last.
- No backpressure. The consumer must accept every poolVld cycle. Back-to-back covResVld every cycle is supported.

## Timing

- Latency: covResVld accepted at cycle t → poolVld at t+2, same order, no gaps inserted.
- Throughput: 1 group/cycle.
- Reset values: poolVld=0, poolPix=0, poolAddr=0, mapDone=0, busy=0, err=0, state=IDLE, acceptCnt=0, pipeline valids=0.
- rst mid-map flushes both pipeline stages. No poolVld or mapDone follows, and a new start is required.
- Outputs hold their last values when poolVld=0, except mapDone, which is a pulse.
- busy rises the cycle after start and falls the cycle after mapDone.
- start arriving in the mapDone cycle is ignored, because the FSM is still in RUN. A new start is accepted one cycle later.
- start and covResVld in the same IDLE cycle: start is taken, the group is dropped and err is set.

## Structure

- Shared package `lenet_pkg` holds:
  - DATA_SIZE, HALFWORD_WIDTH, KENNEL_SIZE;
  - per-layer OUT_DIM/SHIFT constants: layer1 OUT_DIM=12, layer2 OUT_DIM=4;
  - FSM state encoding.
- One natural sub-module, `relu_cut_sat`: combinational ReLU + shift + saturate, reused by later fully-connected stages.
- The max tree and the counters stay inline.

## Test plan

- Basic: start, then one group num=0x0100,0x0050,0xFF00,0x0020 (SHIFT=4) → poolPix=0x10 and poolAddr=0 two cycles later. No mapDone.
- Saturate and negative:
  - 0x7FFF,0,0,0 → poolPix=0x7F.
  - All four 0x8000..0xFFF0 negative → poolPix=0x00.
  - 0x000F → 0x00 (truncation).
- Full map streaming: start, then 144 back-to-back groups with num1=index<<4 → 144 poolVld with poolAddr 0..143 and poolPix=min(index,127). mapDone only with addr 143. busy drops the next cycle.
- Protocol errors:
  - covResVld before start → err=1, no poolVld.
  - 145th group after a full map → dropped, err=1.
  - start during RUN → no restart; addresses continue.
- Reset mid-map: rst asserted after 50 groups with 2 in flight → no further poolVld; all outputs at reset values next cycle. New start → addresses restart at 0.
- Gapped input: covResVld toggling randomly over 144 groups → order preserved and latency exactly 2 for each.
